// File: rtl/pedal_pkg.sv
// Shared constants for the pedal sensor front end and the desired-drive block.
package pedal_pkg;

    localparam int unsigned TORQ_W    = 12;
    localparam int unsigned CAD_W     = 5;
    localparam int unsigned ACC_W     = 17;
    localparam int unsigned AVG_SHIFT = 5;

    // Largest cadence count; the desired-drive block treats this as "at least 31".
    localparam logic [CAD_W-1:0] CAD_SAT = 5'd31;

    // Add one stroke to a cadence count, holding at CAD_SAT instead of wrapping.
    function automatic logic [CAD_W-1:0] cad_sat_inc(input logic [CAD_W-1:0] cnt,
                                                     input logic             inc);
        if (inc && (cnt != CAD_SAT)) begin
            return cnt + 1'b1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/cadence_filt.sv
// Cadence sensor conditioning: two-flop synchronizer, level debounce and
// a registered one-cycle pulse on each filtered rising edge.
module cadence_filt #(
    parameter int unsigned DEB_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic cadence_raw,
    output logic cad_rise
);

    localparam int unsigned DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

    logic             sync_meta;
    logic             cad_sync;
    logic             cad_filt;
    logic             cad_filt_next;
    logic [DEB_W-1:0] deb_cnt;
    logic [DEB_W-1:0] deb_cnt_next;

    // Bring the asynchronous magnet sensor into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            cad_sync  <= 1'b0;
        end else begin
            sync_meta <= cadence_raw;
            cad_sync  <= sync_meta;
        end
    end

    // Debounce: the filtered level follows only after DEB_CYC consecutive disagreeing cycles.
    always_comb begin
        deb_cnt_next  = '0;
        cad_filt_next = cad_filt;
        if (cad_sync != cad_filt) begin
            if (deb_cnt == DEB_LAST) begin
                cad_filt_next = cad_sync;
            end else begin
                deb_cnt_next = deb_cnt + 1'b1;
            end
        end
    end

    // Debounce state and the rising-edge pulse, aligned with the first cycle cad_filt reads 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt  <= '0;
            cad_filt <= 1'b0;
            cad_rise <= 1'b0;
        end else begin
            deb_cnt  <= deb_cnt_next;
            cad_filt <= cad_filt_next;
            cad_rise <= cad_filt_next & ~cad_filt;
        end
    end

endmodule

// File: rtl/pedal_sense.sv
// Pedal sensor front end: produces the cadence count per window and the
// stroke-sampled exponential torque average for the desired-drive block.
// Optional build macro PEDAL_SENSE_IDLE_DECAY_EN: when defined, a window with
// no strokes clears the torque average so assist collapses once pedalling stops.
module pedal_sense
    import pedal_pkg::*;
#(
    parameter int unsigned DEB_CYC  = 1024,
    parameter int unsigned WIN_BITS = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cadence_raw,
    input  logic [TORQ_W-1:0] torque,
    input  logic              torque_vld,
    output logic              cad_rise,
    output logic [CAD_W-1:0]  cadence_vec,
    output logic [TORQ_W-1:0] avg_torque
);

    logic [WIN_BITS-1:0] win_cnt;
    logic                win_last;
    logic [CAD_W-1:0]    edge_cnt;
    logic [CAD_W-1:0]    edge_sum;
    logic [TORQ_W-1:0]   torq_lat;
    logic [TORQ_W-1:0]   torq_sel;
    logic [ACC_W-1:0]    accum;
    logic [ACC_W-1:0]    accum_next;

    cadence_filt #(
        .DEB_CYC (DEB_CYC)
    ) u_cadence_filt (
        .clk         (clk),
        .rst         (rst),
        .cadence_raw (cadence_raw),
        .cad_rise    (cad_rise)
    );

    assign win_last = &win_cnt;
    // A rise on the terminal cycle still belongs to the closing window.
    assign edge_sum = cad_sat_inc(edge_cnt, cad_rise);

    // Free-running window timer; wraps naturally from all-ones to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt <= '0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
        end
    end

    // Count strokes within the window and publish the count at the window boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt    <= '0;
            cadence_vec <= '0;
        end else if (win_last) begin
            edge_cnt    <= '0;
            cadence_vec <= edge_sum;
        end else begin
            edge_cnt    <= edge_sum;
        end
    end

    // Hold the most recent valid torque sample for strokes that arrive between samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            torq_lat <= '0;
        end else if (torque_vld) begin
            torq_lat <= torque;
        end
    end

    // Averager update: one step of a 1/32 exponential filter per pedal stroke.
    always_comb begin
        torq_sel   = torque_vld ? torque : torq_lat;
        accum_next = accum;
        if (cad_rise) begin
            // Steady state is bounded by 32*4095, so the 17-bit sum cannot overflow.
            accum_next = accum - (accum >> AVG_SHIFT) + ACC_W'(torq_sel);
        end
`ifdef PEDAL_SENSE_IDLE_DECAY_EN
        if (win_last && (edge_sum == '0)) begin
            accum_next = '0;
        end
`endif
    end

    // Averager state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            accum <= '0;
        end else begin
            accum <= accum_next;
        end
    end

    assign avg_torque = accum[ACC_W-1:AVG_SHIFT];

endmodule

// File: tb/tb_pedal_sense.sv
// Directed self-checking bench for pedal_sense with DEB_CYC=4, WIN_BITS=8.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pedal_sense;

    localparam int unsigned DEB = 4;
    localparam int unsigned WB  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cadence_raw = 1'b0;
    logic [11:0] torque = '0;
    logic        torque_vld = 1'b0;
    logic        cad_rise;
    logic [4:0]  cadence_vec;
    logic [11:0] avg_torque;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    pedal_sense #(
        .DEB_CYC  (DEB),
        .WIN_BITS (WB)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .cadence_raw (cadence_raw),
        .torque      (torque),
        .torque_vld  (torque_vld),
        .cad_rise    (cad_rise),
        .cadence_vec (cadence_vec),
        .avg_torque  (avg_torque)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle(input int cycles);
        cadence_raw = 1'b0;
        torque_vld  = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    // One raw pulse: hi cycles high, lo cycles low. Torque is base_tq/base_vld except at
    // index inj_idx where inj_tq is presented with torque_vld. Reports rises seen and the
    // index (cycles after the raw level is first sampled) of the first rise.
    task automatic pulse(input int hi, input int lo,
                         input logic [11:0] base_tq, input logic base_vld,
                         input int inj_idx, input logic [11:0] inj_tq,
                         output int n_rise, output int first);
        n_rise = 0;
        first  = -1;
        for (int i = 0; i < hi + lo; i++) begin
            cadence_raw = (i < hi);
            if (i == inj_idx) begin
                torque     = inj_tq;
                torque_vld = 1'b1;
            end else begin
                torque     = base_tq;
                torque_vld = base_vld;
            end
            @(negedge clk);
            if (cad_rise) begin
                n_rise++;
                if (first < 0) first = i;
            end
        end
        torque_vld = 1'b0;
    endtask

    task automatic square(input int half, input int cycles);
        torque_vld = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            cadence_raw = ((i / half) % 2) == 0;
            @(negedge clk);
        end
    endtask

    initial begin
        int nr;
        int fr;

        // 1: reset with busy inputs
        @(negedge clk);
        cadence_raw = 1'b1;
        torque      = 12'hABC;
        torque_vld  = 1'b1;
        do_reset(3);
        cadence_raw = 1'b0;
        torque_vld  = 1'b0;
        @(negedge clk);
        check("reset_cad_rise", cad_rise, 0);
        check("reset_cadence_vec", cadence_vec, 0);
        check("reset_avg_torque", avg_torque, 0);

        // 2: glitch rejection, then a pulse long enough to pass
        do_reset(1);
        pulse(3, 12, 12'h0, 1'b0, -1, 12'h0, nr, fr);
        check("glitch_3cyc_rises", nr, 0);
        pulse(6, 12, 12'h0, 1'b0, -1, 12'h0, nr, fr);
        check("pulse_6cyc_rises", nr, 1);
        check("pulse_6cyc_latency", fr, 1 + DEB);

        // 3: cadence count per window
        do_reset(1);
        square(16, 255);
        check("sq32_before_close", cadence_vec, 0);
        square(16, 1);
        check("sq32_first_window", cadence_vec, 8);
        do_reset(1);
        square(4, 256);
        check("sq8_first_window_sat", cadence_vec, 31);
        square(4, 256);
        check("sq8_second_window_sat", cadence_vec, 31);

        // 4: averager, continuous valid torque then bypass on the stroke cycle
        do_reset(1);
        pulse(8, 8, 12'h800, 1'b1, -1, 12'h0, nr, fr);
        check("avg_stroke1", avg_torque, 12'h040);
        pulse(8, 8, 12'h800, 1'b1, -1, 12'h0, nr, fr);
        check("avg_stroke2", avg_torque, 12'h07E);
        // accum 0xFC0 - 0x7E + 0x100 = 0x1042
        pulse(8, 8, 12'h800, 1'b0, 1 + DEB + 1, 12'h100, nr, fr);
        check("avg_bypass", avg_torque, 12'h082);

        // 5: idle windows (48 cycles into the window so far)
        idle(208);
        check("idle_first_close_cnt", cadence_vec, 3);
        check("idle_first_close_avg", avg_torque, 12'h082);
        idle(256);
        check("idle_empty_window_cnt", cadence_vec, 0);
`ifdef PEDAL_SENSE_IDLE_DECAY_EN
        check("idle_empty_window_avg", avg_torque, 12'h000);
`else
        check("idle_empty_window_avg", avg_torque, 12'h082);
`endif

        // 6: reset mid-window with edge_cnt=3 at win_cnt=100
        do_reset(1);
        for (int p = 0; p < 3; p++) pulse(8, 8, 12'h800, 1'b1, -1, 12'h0, nr, fr);
        idle(52);
        check("midrst_avg_before", avg_torque, 12'h0BA);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_cad_rise", cad_rise, 0);
        check("midrst_cadence_vec", cadence_vec, 0);
        check("midrst_avg_torque", avg_torque, 0);
        pulse(8, 8, 12'h800, 1'b1, -1, 12'h0, nr, fr);
        pulse(8, 8, 12'h800, 1'b1, -1, 12'h0, nr, fr);
        idle(223);
        check("midrst_no_early_close", cadence_vec, 0);
        idle(1);
        check("midrst_close_at_256", cadence_vec, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
